// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 Hz timing constants and sync-polarity helper shared by the
// VGA sync generator and its line counter.
package vga_timing_pkg;

  localparam int unsigned H_VISIBLE_DFLT = 640;
  localparam int unsigned H_FRONT_DFLT   = 16;
  localparam int unsigned H_SYNC_DFLT    = 96;
  localparam int unsigned H_BACK_DFLT    = 48;
  localparam int unsigned V_VISIBLE_DFLT = 480;
  localparam int unsigned V_FRONT_DFLT   = 10;
  localparam int unsigned V_SYNC_DFLT    = 2;
  localparam int unsigned V_BACK_DFLT    = 33;

  localparam int unsigned H_TOTAL_DFLT = H_VISIBLE_DFLT + H_FRONT_DFLT + H_SYNC_DFLT + H_BACK_DFLT;
  localparam int unsigned V_TOTAL_DFLT = V_VISIBLE_DFLT + V_FRONT_DFLT + V_SYNC_DFLT + V_BACK_DFLT;

  // Sync windows are half-open: [START, END).
  localparam int unsigned H_SYNC_START_DFLT = H_VISIBLE_DFLT + H_FRONT_DFLT;
  localparam int unsigned H_SYNC_END_DFLT   = H_SYNC_START_DFLT + H_SYNC_DFLT;
  localparam int unsigned V_SYNC_START_DFLT = V_VISIBLE_DFLT + V_FRONT_DFLT;
  localparam int unsigned V_SYNC_END_DFLT   = V_SYNC_START_DFLT + V_SYNC_DFLT;

  function automatic logic sync_level(input logic asserted, input bit active_low);
    return active_low ? ~asserted : asserted;
  endfunction

endpackage

// File: rtl/vga_sync_generator_vertical_line_counter.sv
// Vertical line counter: advances on each end_of_line, wraps at V_TOTAL-1 with a
// one-cycle end_of_frame strobe, and tracks completed frames and the lock flag.
module vertical_line_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned V_TOTAL = V_TOTAL_DFLT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       end_of_line_i,
  output logic [9:0] v_count_o,
  output logic       end_of_frame_o,
  output logic [7:0] frame_count_o,
  output logic       locked_o
);

  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

  logic [9:0] v_count_q, v_count_d;
  logic       eof_q, eof_d;
  logic [7:0] frame_count_q, frame_count_d;
  logic       locked_q, locked_d;

  always_comb begin
    v_count_d     = v_count_q;
    eof_d         = 1'b0;
    frame_count_d = frame_count_q;
    locked_d      = locked_q;
    if (end_of_line_i) begin
      if (v_count_q == V_LAST) begin
        v_count_d     = '0;
        eof_d         = 1'b1;
        frame_count_d = frame_count_q + 8'd1;
        locked_d      = 1'b1;
      end else begin
        v_count_d = v_count_q + 10'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_count_q     <= '0;
      eof_q         <= 1'b0;
      frame_count_q <= '0;
      locked_q      <= 1'b0;
    end else begin
      v_count_q     <= v_count_d;
      eof_q         <= eof_d;
      frame_count_q <= frame_count_d;
      locked_q      <= locked_d;
    end
  end

  assign v_count_o      = v_count_q;
  assign end_of_frame_o = eof_q;
  assign frame_count_o  = frame_count_q;
  assign locked_o       = locked_q;

endmodule

// File: rtl/vga_sync_generator.sv
// VGA sync generator: registered hsync/vsync/video_on/pixel coordinates decoded from
// the upstream hCount and the internal line counter, one cycle behind the inputs.
module vga_sync_generator
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_VISIBLE       = H_VISIBLE_DFLT,
  parameter int unsigned H_FRONT         = H_FRONT_DFLT,
  parameter int unsigned H_SYNC          = H_SYNC_DFLT,
  parameter int unsigned V_VISIBLE       = V_VISIBLE_DFLT,
  parameter int unsigned V_FRONT         = V_FRONT_DFLT,
  parameter int unsigned V_SYNC          = V_SYNC_DFLT,
  parameter int unsigned V_BACK          = V_BACK_DFLT,
  parameter bit          SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] hCount,
  input  logic       end_of_line,
  output logic [9:0] vCount,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       end_of_frame,
  output logic [7:0] frame_count,
  output logic       locked
);

  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_VIS_LIM    = 10'(H_VISIBLE);
  localparam logic [9:0] H_SYNC_START = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] H_SYNC_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] V_VIS_LIM    = 10'(V_VISIBLE);
  localparam logic [9:0] V_SYNC_START = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] V_SYNC_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic       SYNC_IDLE    = SYNC_ACTIVE_LOW ? 1'b1 : 1'b0;

  logic [9:0] v_count;
  logic       locked_w;

  vertical_line_counter #(
    .V_TOTAL (V_TOTAL)
  ) u_vcnt (
    .clk            (clk),
    .rst_n          (rst_n),
    .end_of_line_i  (end_of_line),
    .v_count_o      (v_count),
    .end_of_frame_o (end_of_frame),
    .frame_count_o  (frame_count),
    .locked_o       (locked_w)
  );

  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       video_on_q, video_on_d;
  logic [9:0] pixel_x_q, pixel_y_q;

  // Decode uses the line counter value before any same-edge increment.
  always_comb begin
    hsync_d    = sync_level((hCount >= H_SYNC_START) && (hCount < H_SYNC_END), SYNC_ACTIVE_LOW);
    vsync_d    = sync_level((v_count >= V_SYNC_START) && (v_count < V_SYNC_END), SYNC_ACTIVE_LOW);
    video_on_d = (hCount < H_VIS_LIM) && (v_count < V_VIS_LIM) && locked_w;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync_q    <= SYNC_IDLE;
      vsync_q    <= SYNC_IDLE;
      video_on_q <= 1'b0;
      pixel_x_q  <= '0;
      pixel_y_q  <= '0;
    end else begin
      hsync_q    <= hsync_d;
      vsync_q    <= vsync_d;
      video_on_q <= video_on_d;
      pixel_x_q  <= hCount;
      pixel_y_q  <= v_count;
    end
  end

  assign vCount   = v_count;
  assign locked   = locked_w;
  assign hsync    = hsync_q;
  assign vsync    = vsync_q;
  assign video_on = video_on_q;
  assign pixel_x  = pixel_x_q;
  assign pixel_y  = pixel_y_q;

endmodule

// File: tb/tb_vga_sync_generator.sv
// Randomized bench for vga_sync_generator: a default-timing instance and a short-frame
// instance share the inputs and are compared each cycle to an arithmetic reference.
module tb_vga_sync_generator;

  logic       clk;
  logic       rst_n;
  logic [9:0] hCount;
  logic       end_of_line;

  logic [9:0] vc_a, px_a, py_a, vc_b, px_b, py_b;
  logic       hs_a, vs_a, von_a, eof_a, lk_a;
  logic       hs_b, vs_b, von_b, eof_b, lk_b;
  logic [7:0] fc_a, fc_b;

  int checks = 0;
  int errors = 0;

  vga_sync_generator dut_a (
    .clk(clk), .rst_n(rst_n), .hCount(hCount), .end_of_line(end_of_line),
    .vCount(vc_a), .hsync(hs_a), .vsync(vs_a), .video_on(von_a),
    .pixel_x(px_a), .pixel_y(py_a), .end_of_frame(eof_a),
    .frame_count(fc_a), .locked(lk_a)
  );

  vga_sync_generator #(
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .hCount(hCount), .end_of_line(end_of_line),
    .vCount(vc_b), .hsync(hs_b), .vsync(vs_b), .video_on(von_b),
    .pixel_x(px_b), .pixel_y(py_b), .end_of_frame(eof_b),
    .frame_count(fc_b), .locked(lk_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: per-instance frame geometry and expected outputs.
  int VT[2]   = '{525, 7};
  int VVIS[2] = '{480, 4};
  int VS0[2]  = '{490, 5};
  int VS1[2]  = '{492, 6};
  int mv[2], mfc[2], epx[2], epy[2];
  bit mlk[2], meof[2], ehs[2], evs[2], evon[2];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mv[i] = 0; mfc[i] = 0; mlk[i] = 0; meof[i] = 0;
      ehs[i] = 1; evs[i] = 1; evon[i] = 0; epx[i] = 0; epy[i] = 0;
    end
  endtask

  task automatic model_edge(input int hc, input bit eol);
    for (int i = 0; i < 2; i++) begin
      ehs[i]  = !(hc >= 656 && hc < 752);
      evs[i]  = !(mv[i] >= VS0[i] && mv[i] < VS1[i]);
      evon[i] = (hc < 640) && (mv[i] < VVIS[i]) && mlk[i];
      epx[i]  = hc;
      epy[i]  = mv[i];
      meof[i] = 0;
      if (eol) begin
        mv[i] = mv[i] + 1;
        if (mv[i] == VT[i]) begin
          mv[i]   = 0;
          meof[i] = 1;
          mfc[i]  = (mfc[i] + 1) % 256;
          mlk[i]  = 1;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_inst(input string p, input int i, input logic [9:0] vc,
                            input logic hs, input logic vs, input logic von,
                            input logic [9:0] px, input logic [9:0] py,
                            input logic eof, input logic [7:0] fc, input logic lk);
    chk({p, ".vCount"},       32'(vc),  32'(mv[i]));
    chk({p, ".hsync"},        32'(hs),  32'(ehs[i]));
    chk({p, ".vsync"},        32'(vs),  32'(evs[i]));
    chk({p, ".video_on"},     32'(von), 32'(evon[i]));
    chk({p, ".pixel_x"},      32'(px),  32'(epx[i]));
    chk({p, ".pixel_y"},      32'(py),  32'(epy[i]));
    chk({p, ".end_of_frame"}, 32'(eof), 32'(meof[i]));
    chk({p, ".frame_count"},  32'(fc),  32'(mfc[i]));
    chk({p, ".locked"},       32'(lk),  32'(mlk[i]));
  endtask

  task automatic check_all();
    check_inst("A", 0, vc_a, hs_a, vs_a, von_a, px_a, py_a, eof_a, fc_a, lk_a);
    check_inst("B", 1, vc_b, hs_b, vs_b, von_b, px_b, py_b, eof_b, fc_b, lk_b);
  endtask

  task automatic step(input logic [9:0] hc, input logic eol);
    hCount      = hc;
    end_of_line = eol;
    @(posedge clk);
    if (rst_n) model_edge(int'(hc), eol);
    #1;
    check_all();
  endtask

  function automatic logic [9:0] rnd_h();
    return 10'($urandom_range(0, 1023));
  endfunction

  task automatic advance_a(input int target);
    for (int n = 0; n < 1100 && mv[0] != target; n++) step(rnd_h(), 1'b1);
    chk("advance_a", 32'(mv[0]), 32'(target));
  endtask

  int fc_b_before;

  initial begin
    rst_n       = 1'b1;
    hCount      = '0;
    end_of_line = 1'b0;
    model_reset();
    #2 rst_n = 1'b0;
    #1 check_all();
    end_of_line = 1'b1;
    @(posedge clk);
    #1 check_all();
    #2 rst_n = 1'b1;

    // Full horizontal sweep with no line strobes.
    for (int h = 0; h < 800; h++) step(10'(h), 1'b0);
    chk("sweep.locked", 32'(lk_a), 32'd0);

    // One full frame of back-to-back strobes.
    repeat (525) step(rnd_h(), 1'b1);
    chk("frame1.eof",    32'(eof_a), 32'd1);
    chk("frame1.fc",     32'(fc_a),  32'd1);
    chk("frame1.locked", 32'(lk_a),  32'd1);

    // Vertical sync window edges.
    advance_a(489);
    step(10'd100, 1'b0);
    chk("vsync@489", 32'(vs_a), 32'd1);
    step(10'd100, 1'b1);
    step(10'd100, 1'b0);
    chk("vsync@490", 32'(vs_a), 32'd0);
    step(10'd100, 1'b1);
    step(10'd100, 1'b0);
    chk("vsync@491", 32'(vs_a), 32'd0);
    step(10'd100, 1'b1);
    step(10'd100, 1'b0);
    chk("vsync@492", 32'(vs_a), 32'd1);

    // Visible-area corner.
    advance_a(479);
    step(10'd639, 1'b0);
    chk("corner.video_on", 32'(von_a), 32'd1);
    chk("corner.pixel_x",  32'(px_a),  32'd639);
    chk("corner.pixel_y",  32'(py_a),  32'd479);
    step(10'd640, 1'b0);
    chk("h640.video_on",   32'(von_a), 32'd0);

    // Random mix of hCount values (including out-of-range) and sparse strobes.
    repeat (3000) step(rnd_h(), ($urandom_range(0, 3) == 0));

    // 256 short frames on the compact instance: frame_count wraps back.
    fc_b_before = mfc[1];
    repeat (256 * 7) step(rnd_h(), 1'b1);
    chk("B.fc_wrap",   32'(fc_b), 32'(fc_b_before));
    chk("B.locked256", 32'(lk_b), 32'd1);

    // Asynchronous reset mid-frame with a simultaneous line strobe.
    advance_a(300);
    hCount      = 10'd50;
    end_of_line = 1'b1;
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_all();
    @(posedge clk);
    #1 check_all();
    #3 rst_n = 1'b1;
    step(10'd10, 1'b0);
    repeat (524) step(rnd_h(), 1'b1);
    chk("relock.pre",  32'(lk_a), 32'd0);
    step(rnd_h(), 1'b1);
    chk("relock.post", 32'(lk_a), 32'd1);
    repeat (20) step(rnd_h(), 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_sync_generator.md
Name: vga_sync_generator

Overview:
- Sits directly downstream of the horizontal pixel counter and consumes its hCount and end_of_line outputs.
- Holds the vertical line counter and produces registered hsync, vsync, video_on, pixel coordinates, and frame-level strobes for the pixel-generation logic and the VGA pins.
- Default timing is 640x480 at 60 Hz on a 25 MHz pixel clock.

Parameters:
- H_VISIBLE, 640, active pixels per line
- H_FRONT, 16, horizontal front porch, in pixels
- H_SYNC, 96, hsync pulse width, in pixels
- V_VISIBLE, 480, active lines per frame
- V_FRONT, 10, vertical front porch, in lines
- V_SYNC, 2, vsync pulse width, in lines
- V_BACK, 33, vertical back porch, in lines
- SYNC_ACTIVE_LOW, 1, 1 means hsync/vsync are asserted low

Ports:
- clk  input  1  pixel clock
- rst_n  input  1  asynchronous active-low reset
- hCount  input  10  current horizontal pixel index from the upstream counter
- end_of_line  input  1  one-cycle strobe on the last pixel of a line
- vCount  output  10  current line index, 0..V_TOTAL-1
- hsync  output  1  horizontal sync, polarity per SYNC_ACTIVE_LOW
- vsync  output  1  vertical sync, polarity per SYNC_ACTIVE_LOW
- video_on  output  1  high while the current pixel is in the visible area and locked is high
- pixel_x  output  10  hCount registered; valid while video_on=1
- pixel_y  output  10  vCount registered; valid while video_on=1
- end_of_frame  output  1  one-cycle strobe on the last line wrap
- frame_count  output  8  count of completed frames, wraps at 255 to 0
- locked  output  1  high once the first full frame has been counted

Behaviour:
- Derived constant: V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK (default 525).
- Reset: rst_n=0 asynchronously forces the following, with no dependence on clk.
  - vCount=0, pixel_x=0, pixel_y=0, frame_count=0.
  - end_of_frame=0, locked=0, video_on=0.
  - hsync and vsync go to their inactive level (1 when SYNC_ACTIVE_LOW=1).
- Line counting:
  - On a clk edge with end_of_line=1, vCount increments.
  - If vCount==V_TOTAL-1 on that edge, vCount wraps to 0 and end_of_frame=1 for exactly that following cycle.
  - Otherwise end_of_frame=0.
- frame_count and locked:
  - frame_count increments on each end_of_frame, modulo 256.
  - locked goes high on the first end_of_frame and stays high until reset.
- Registered outputs: hsync, vsync, video_on, pixel_x and pixel_y all have 1-cycle latency from hCount and the current vCount.
- Horizontal sync:
  - Asserted when H_VISIBLE+H_FRONT <= hCount < H_VISIBLE+H_FRONT+H_SYNC.
  - Default window is 656..751.
- Vertical sync:
  - Asserted when V_VISIBLE+V_FRONT <= vCount < V_VISIBLE+V_FRONT+V_SYNC.
  - Default window is 490..491.
- Visible area: video_on = (hCount < H_VISIBLE) AND (vCount < V_VISIBLE) AND locked.
- Out-of-range hCount: any hCount >= H_VISIBLE+H_FRONT+H_SYNC, including the upstream terminal value 800, is blanking. No sync is asserted and no error is flagged.
- Same-edge end_of_line: the sync and video_on decode on that edge uses the pre-increment vCount.
- Boundaries:
  - end_of_line while vCount==V_TOTAL-1 wraps and strobes in the same edge.
  - Consecutive end_of_line strobes are each counted.
  - end_of_line=1 while rst_n=0 is ignored.
  - Reset release mid-line: counting resumes from vCount=0 at the next end_of_line. locked stays 0 until the next full wrap, so the partial first frame is never shown.
- Width rules:
  - All compares are unsigned, 10 bits.
  - Parameters must give V_TOTAL <= 1024 and H_VISIBLE+H_FRONT+H_SYNC <= 1023.

Decomposition:
- Package vga_timing_pkg holds:
  - the timing constants (H_*, V_*, V_TOTAL, the sync window start/end values);
  - a localparam function for sync polarity application.
- One natural sub-module, vertical_line_counter:
  - contains the vCount register, wrap logic, end_of_frame, frame_count and locked;
  - the top level keeps the registered decode logic.

Test Plan:
- Reset then 800 cycles with end_of_line=0 and hCount sweeping 0..799 -> vCount=0, locked=0, video_on=0 throughout; hsync=0 exactly for hCount 656..751, observed one cycle later.
- 525 end_of_line strobes from reset -> vCount counts 0..524, wraps to 0; end_of_frame=1 for one cycle; frame_count=1; locked=1.
- After lock, vCount=490 and 491 -> vsync=0 on those lines; vCount=489 and 492 -> vsync=1.
- After lock, hCount=639 with vCount=479 -> video_on=1, pixel_x=639, pixel_y=479; hCount=640 -> video_on=0.
- 256 full frames -> frame_count returns to 0 while locked stays 1.
- rst_n pulsed low at vCount=300 with end_of_line asserted in the same cycle -> all outputs return to reset values immediately; after release, locked=0 until 525 more end_of_line strobes.
